// File: rtl/controle_responder.sv
// controle_responder: pad-side responder for the DB9 Mega Drive-style link.
// It follows the host Select line through the 3/6-button phase sequence and
// drives the six active-low data pins from a registered copy of Botoes.
// Fase is exported so a bench or logic analyser can follow the protocol.
module controle_responder #(
  parameter int TIMEOUT_CICLOS = 75000,
  parameter int SEIS_BOTOES    = 1
) (
  input  logic        Clock50,
  input  logic        Reset,
  input  logic        Select,
  input  logic [11:0] Botoes,
  output logic        Pino1,
  output logic        Pino2,
  output logic        Pino3,
  output logic        Pino4,
  output logic        Pino6,
  output logic        Pino9,
  output logic [2:0]  Fase
);

  // Counter wide enough to hold TIMEOUT_CICLOS-1.
  localparam int CNT_W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CICLOS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Bit positions inside Botoes (pressed = 1).
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_X     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_Z     = 10;
  localparam int BTN_MODE  = 11;

  // Phase parity rule: even phases belong to Select high, odd to Select low.
  function automatic logic fase_parity_ok(input logic [2:0] f, input logic sel);
    return (f[0] == ~sel);
  endfunction

  // Phase to fall back to whenever the sequence has to be resynchronised.
  function automatic logic [2:0] fase_resync(input logic sel);
    return sel ? 3'd0 : 3'd1;
  endfunction

  // In 3-button mode the extra phases alias onto the plain Select levels.
  function automatic logic [2:0] fase_decode(input logic [2:0] f);
    logic [2:0] eff;
    eff = f;
    if (SEIS_BOTOES == 0) begin
      case (f)
        3'd5:    eff = 3'd1;
        3'd6:    eff = 3'd0;
        3'd7:    eff = 3'd1;
        default: eff = f;
      endcase
    end else begin
      eff = f;
    end
    return eff;
  endfunction

  logic             sel_meta_r;
  logic             sel_sync_r;
  logic             sel_prev_r;
  logic [11:0]      btn_r;
  logic [2:0]       fase_r;
  logic [CNT_W-1:0] cnt_r;
  logic [5:0]       pins_r;

  logic             sel_edge_s;
  logic             timeout_s;
  logic [2:0]       fase_inc_s;
  logic [2:0]       fase_next_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic [2:0]       fase_eff_s;
  logic [5:0]       pins_next_s;

  // Bring Select into the Clock50 domain and keep one extra stage for edges.
  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      sel_meta_r <= 1'b1;
      sel_sync_r <= 1'b1;
      sel_prev_r <= 1'b1;
    end else begin
      sel_meta_r <= Select;
      sel_sync_r <= sel_meta_r;
      sel_prev_r <= sel_sync_r;
    end
  end

  // Register the button vector once; no debounce is wanted here.
  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      btn_r <= 12'h000;
    end else begin
      btn_r <= Botoes;
    end
  end

  // Next phase and idle counter: a Select edge has priority over the timeout.
  always_comb begin
    sel_edge_s  = sel_sync_r ^ sel_prev_r;
    timeout_s   = (cnt_r == CNT_MAX);
    fase_inc_s  = fase_r + 3'd1;
    fase_next_s = fase_r;
    cnt_next_s  = cnt_r;
    if (sel_edge_s) begin
      cnt_next_s = '0;
      if (fase_parity_ok(fase_inc_s, sel_sync_r)) begin
        fase_next_s = fase_inc_s;
      end else begin
        fase_next_s = fase_resync(sel_sync_r);
      end
    end else if (timeout_s) begin
      cnt_next_s  = cnt_r;
      fase_next_s = fase_resync(sel_sync_r);
    end else begin
      cnt_next_s  = cnt_r + CNT_ONE;
      fase_next_s = fase_r;
    end
  end

  // Hold the phase and idle-counter state.
  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      fase_r <= 3'd0;
      cnt_r  <= '0;
    end else begin
      fase_r <= fase_next_s;
      cnt_r  <= cnt_next_s;
    end
  end

  // Pin levels {P1,P2,P3,P4,P6,P9} for the current phase; pressed drives low.
  always_comb begin
    fase_eff_s  = fase_decode(fase_r);
    pins_next_s = 6'b111111;
    case (fase_eff_s)
      3'd0, 3'd2, 3'd4: begin
        pins_next_s = ~{btn_r[BTN_UP], btn_r[BTN_DOWN], btn_r[BTN_LEFT],
                        btn_r[BTN_RIGHT], btn_r[BTN_B], btn_r[BTN_C]};
      end
      3'd1, 3'd3: begin
        pins_next_s = {~btn_r[BTN_UP], ~btn_r[BTN_DOWN], 1'b0, 1'b0,
                       ~btn_r[BTN_A], ~btn_r[BTN_START]};
      end
      3'd5: begin
        pins_next_s = {4'b0000, ~btn_r[BTN_A], ~btn_r[BTN_START]};
      end
      3'd6: begin
        pins_next_s = ~{btn_r[BTN_Z], btn_r[BTN_Y], btn_r[BTN_X],
                        btn_r[BTN_MODE], btn_r[BTN_B], btn_r[BTN_C]};
      end
      3'd7: begin
        pins_next_s = {4'b1111, ~btn_r[BTN_A], ~btn_r[BTN_START]};
      end
      default: begin
        pins_next_s = 6'b111111;
      end
    endcase
  end

  // Output register for the data pins; released (high) while in reset.
  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      pins_r <= 6'b111111;
    end else begin
      pins_r <= pins_next_s;
    end
  end

  assign Pino1 = pins_r[5];
  assign Pino2 = pins_r[4];
  assign Pino3 = pins_r[3];
  assign Pino4 = pins_r[2];
  assign Pino6 = pins_r[1];
  assign Pino9 = pins_r[0];
  assign Fase  = fase_r;

endmodule

// File: tb/tb_controle_responder.sv
// Bench for controle_responder: a 6-button and a 3-button instance share all
// inputs. Table walk, latency/timeout/reset sequences, then random traffic
// against a phase-level reference model.
module tb_controle_responder;

  localparam int T = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [11:0] btn;

  logic        a1, a2, a3, a4, a6, a9;
  logic        b1, b2, b3, b4, b6, b9;
  logic [2:0]  fase6, fase3;
  logic [5:0]  pins6, pins3;

  int checks = 0;
  int fails  = 0;

  controle_responder #(.TIMEOUT_CICLOS(T), .SEIS_BOTOES(1)) dut6 (
    .Clock50(clk), .Reset(rst_n), .Select(sel), .Botoes(btn),
    .Pino1(a1), .Pino2(a2), .Pino3(a3), .Pino4(a4), .Pino6(a6), .Pino9(a9),
    .Fase(fase6)
  );

  controle_responder #(.TIMEOUT_CICLOS(T), .SEIS_BOTOES(0)) dut3 (
    .Clock50(clk), .Reset(rst_n), .Select(sel), .Botoes(btn),
    .Pino1(b1), .Pino2(b2), .Pino3(b3), .Pino4(b4), .Pino6(b6), .Pino9(b9),
    .Fase(fase3)
  );

  assign pins6 = {a1, a2, a3, a4, a6, a9};
  assign pins3 = {b1, b2, b3, b4, b6, b9};

  always #10 clk = ~clk;

  typedef struct packed {
    logic [11:0] btn;
    logic [2:0]  fase;
    logic [5:0]  p6;
    logic [5:0]  p3;
  } vec_t;

  vec_t tbl [24];

  // Reference model state: phase, synchronised Select level, cycles since toggle.
  int m_fase;
  bit m_sel;
  int m_since;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pin levels {P1,P2,P3,P4,P6,P9} from the protocol rules (pressed -> low).
  function automatic logic [5:0] ref_pins(input int phase, input logic [11:0] b, input bit six);
    int p;
    logic up, dn, lf, rt, ba, bb, bc, st, bx, by, bz, md;
    {md, bz, by, bx, st, bc, bb, ba, rt, lf, dn, up} = b;
    p = phase;
    if (!six && p >= 5) p = (p == 6) ? 0 : 1;
    if (p == 6)      return ~{bz, by, bx, md, bb, bc};
    else if (p == 5) return {4'b0000, ~ba, ~st};
    else if (p == 7) return {4'b1111, ~ba, ~st};
    else if (p % 2 == 0) return ~{up, dn, lf, rt, bb, bc};
    else             return {~up, ~dn, 2'b00, ~ba, ~st};
  endfunction

  task automatic model_toggle();
    m_sel  = !m_sel;
    m_fase = (m_fase + 1) % 8;
    if ((m_fase % 2 == 0) != m_sel) m_fase = m_sel ? 0 : 1;
    m_since = 0;
  endtask

  task automatic model_wait(input int n);
    m_since += n;
    if (m_since >= T + 3) m_fase = m_sel ? 0 : 1;
  endtask

  initial begin
    // Walk tables: 8 Select edges per button pattern, starting from Select high.
    tbl[0]  = '{12'h0FF, 3'd1, 6'b000000, 6'b000000};
    tbl[1]  = '{12'h0FF, 3'd2, 6'b000000, 6'b000000};
    tbl[2]  = '{12'h0FF, 3'd3, 6'b000000, 6'b000000};
    tbl[3]  = '{12'h0FF, 3'd4, 6'b000000, 6'b000000};
    tbl[4]  = '{12'h0FF, 3'd5, 6'b000000, 6'b000000};
    tbl[5]  = '{12'h0FF, 3'd6, 6'b111100, 6'b000000};
    tbl[6]  = '{12'h0FF, 3'd7, 6'b111100, 6'b000000};
    tbl[7]  = '{12'h0FF, 3'd0, 6'b000000, 6'b000000};
    tbl[8]  = '{12'h801, 3'd1, 6'b010011, 6'b010011};
    tbl[9]  = '{12'h801, 3'd2, 6'b011111, 6'b011111};
    tbl[10] = '{12'h801, 3'd3, 6'b010011, 6'b010011};
    tbl[11] = '{12'h801, 3'd4, 6'b011111, 6'b011111};
    tbl[12] = '{12'h801, 3'd5, 6'b000011, 6'b010011};
    tbl[13] = '{12'h801, 3'd6, 6'b111011, 6'b011111};
    tbl[14] = '{12'h801, 3'd7, 6'b111111, 6'b010011};
    tbl[15] = '{12'h801, 3'd0, 6'b011111, 6'b011111};
    tbl[16] = '{12'h700, 3'd1, 6'b110011, 6'b110011};
    tbl[17] = '{12'h700, 3'd2, 6'b111111, 6'b111111};
    tbl[18] = '{12'h700, 3'd3, 6'b110011, 6'b110011};
    tbl[19] = '{12'h700, 3'd4, 6'b111111, 6'b111111};
    tbl[20] = '{12'h700, 3'd5, 6'b000011, 6'b110011};
    tbl[21] = '{12'h700, 3'd6, 6'b000111, 6'b111111};
    tbl[22] = '{12'h700, 3'd7, 6'b111111, 6'b110011};
    tbl[23] = '{12'h700, 3'd0, 6'b111111, 6'b111111};

    // Reset state and a quiet hold.
    rst_n = 1'b0; sel = 1'b1; btn = 12'h000;
    step(3);
    check("reset_pins6", {2'b00, pins6}, 8'h3F);
    check("reset_fase6", {5'b0, fase6}, 8'h00);
    check("reset_pins3", {2'b00, pins3}, 8'h3F);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(10);
      check("idle_pins", {2'b00, pins6}, 8'h3F);
      check("idle_fase", {5'b0, fase6}, 8'h00);
    end

    // Table walk.
    for (int i = 0; i < 24; i++) begin
      btn = tbl[i].btn;
      sel = ~sel;
      step(8);
      check($sformatf("tbl%0d_fase6", i), {5'b0, fase6}, {5'b0, tbl[i].fase});
      check($sformatf("tbl%0d_fase3", i), {5'b0, fase3}, {5'b0, tbl[i].fase});
      check($sformatf("tbl%0d_pins6", i), {2'b00, pins6}, {2'b00, tbl[i].p6});
      check($sformatf("tbl%0d_pins3", i), {2'b00, pins3}, {2'b00, tbl[i].p3});
    end

    // Botoes latency: two clock edges.
    btn = 12'h001;
    step(1);
    check("btn_lat1", {2'b00, pins6}, 8'h3F);
    step(1);
    check("btn_lat2", {2'b00, pins6}, {2'b00, 6'b011111});

    // Select latency: Fase on the 3rd edge, pins on the 4th.
    sel = 1'b0;
    step(2);
    check("sel_lat_fase2", {5'b0, fase6}, 8'h00);
    step(1);
    check("sel_lat_fase3", {5'b0, fase6}, 8'h01);
    check("sel_lat_pins3", {2'b00, pins6}, {2'b00, 6'b011111});
    step(1);
    check("sel_lat_pins4", {2'b00, pins6}, {2'b00, 6'b010011});

    // Timeout: low idle keeps phase 1; after a rising edge, phase 2 falls to 0.
    step(T + 10);
    check("tmo_low_fase", {5'b0, fase6}, 8'h01);
    sel = 1'b1;
    step(3);
    check("tmo_edge_fase", {5'b0, fase6}, 8'h02);
    step(T - 1);
    check("tmo_before", {5'b0, fase6}, 8'h02);
    step(1);
    check("tmo_at", {5'b0, fase6}, 8'h00);

    // Reset while in phase 6 with buttons held.
    btn = 12'h0FF;
    for (int i = 0; i < 6; i++) begin
      sel = ~sel;
      step(8);
    end
    check("ph6_fase", {5'b0, fase6}, 8'h06);
    check("ph6_pins", {2'b00, pins6}, {2'b00, 6'b111100});
    #4 rst_n = 1'b0;
    #1;
    check("async_rst_pins6", {2'b00, pins6}, 8'h3F);
    check("async_rst_pins3", {2'b00, pins3}, 8'h3F);
    check("async_rst_fase", {5'b0, fase6}, 8'h00);
    step(2);
    rst_n = 1'b1;
    step(2);
    sel = 1'b0;
    step(4);
    check("post_rst_fase", {5'b0, fase6}, 8'h01);
    check("post_rst_pins", {2'b00, pins6}, 8'h00);

    // Random traffic against the reference model.
    rst_n = 1'b0; sel = 1'b1; btn = 12'h000;
    step(2);
    rst_n = 1'b1;
    m_fase = 0; m_sel = 1'b1; m_since = 1000;
    for (int i = 0; i < 200; i++) begin
      int gap;
      bit tog;
      tog = ($urandom_range(0, 3) != 0);
      btn = 12'($urandom);
      if (tog) begin
        sel = ~sel;
        model_toggle();
      end
      if ($urandom_range(0, 7) == 0) gap = $urandom_range(T + 10, T + 40);
      else                           gap = $urandom_range(6, 40);
      if (m_since + gap >= T + 1 && m_since + gap <= T + 6) gap += 8;
      step(gap);
      model_wait(gap);
      check("rnd_fase6", {5'b0, fase6}, 8'(m_fase));
      check("rnd_fase3", {5'b0, fase3}, 8'(m_fase));
      check("rnd_pins6", {2'b00, pins6}, {2'b00, ref_pins(m_fase, btn, 1'b1)});
      check("rnd_pins3", {2'b00, pins3}, {2'b00, ref_pins(m_fase, btn, 1'b0)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
